// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO pointer controller: Gray conversion
// and depth derivation. Optional feature macro: FIFO_CTRL_ALMOST_EN.
package fifo_ctrl_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int GRAY_MAX_W = 32;

    typedef logic [DEF_ADDR_W:0] ptr_t;

    // Callers cast to/from GRAY_MAX_W so one function serves every pointer width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_gray_ptr.sv
// Binary pointer counter with enable and synchronous clear; exports the
// registered binary value and its Gray-coded copy.
module fifo_gray_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin <= '0;
        end else if (clr) begin
            bin <= '0;
        end else if (en) begin
            bin <= bin + W'(1);
        end
    end

    assign gray = W'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller driving an external dual-port RAM.
// Optional almost_full/almost_empty flags are built when FIFO_CTRL_ALMOST_EN is defined.
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Flags come straight from the registered pointers, so accept decisions
    // always see the state as of the last edge.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign push      = wr_en && !full;
    assign pop       = rd_en && !empty;
    assign mem_we    = push;
    assign mem_waddr = wr_ptr[ADDR_W-1:0];
    assign mem_raddr = rd_ptr[ADDR_W-1:0];

    fifo_gray_ptr #(.W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (push),
        .bin   (wr_ptr),
        .gray  (wr_ptr_gray)
    );

    fifo_gray_ptr #(.W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (pop),
        .bin   (rd_ptr),
        .gray  (rd_ptr_gray)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (wr_en && full) overflow <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    logic [PW-1:0] count_nxt;

    // Thresholds are evaluated on the post-edge occupancy so the flags line up with count.
    assign count_nxt = clr ? '0 : (count + PW'(push) - PW'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= PW'(AF_LEVEL));
            almost_empty <= (count_nxt <= PW'(AE_LEVEL));
        end
    end
`endif

endmodule
